operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage directly downstream of the instruction parser. It accepts the parsed fields (format, branch flag, opcode, primary register, secondary operand), reads register values from a 32 x 16-bit register file, and resolves the secondary operand as either an immediate or a register. It tracks in-flight destination registers with a scoreboard and stalls upstream on read-after-write hazards. It also owns the register-file write port used by writeback.

## Interface
Parameters:
- DATA_W, 16, register and operand width
- REG_COUNT, 32, number of architectural registers (index width 5)

Ports:
- clock_i  in  1  clock; all state changes on rising edge
- reset_i  in  1  synchronous, active-low reset
- enable_i  in  1  parsed instruction valid
- instructionFormat_i  in  1  1 = immediate form, 0 = register form
- isBranch_i  in  1  branch flag
- opcode_i  in  7  opcode
- primOperand_i  in  5  primary (destination/source) register index
- secOperand_i  in  16  immediate (format 1) or register index in [4:0] (format 0)
- wbEnable_i  in  1  writeback strobe
- wbReg_i  in  5  writeback register index
- wbData_i  in  16  writeback data
- stall_o  out  1  upstream must hold its outputs and deassert its enable
- enable_o  out  1  operands valid
- instructionFormat_o  out  1  passed through
- isBranch_o  out  1  passed through
- opcode_o  out  7  passed through
- primReg_o  out  5  primary register index
- primValue_o  out  16  primary register value
- secValue_o  out  16  immediate or secondary register value

## Operation
- Accept: cycle with enable_i=1 and stall_o=0.
- Hazard: the primary register is busy, or format 0 and register secOperand_i[4:0] is busy. Format 1 never checks the secondary field.
- Scoreboard: 32 busy bits.
  - Set for primOperand when a non-branch instruction issues to the outputs.
  - Branches never set busy.
  - Cleared on wbEnable_i for wbReg_i.
  - Same-cycle set and clear of the same register: set wins.
- State machine RUN/STALL.
  - RUN: an accepted instruction with no hazard issues next cycle. An accepted instruction with a hazard is captured into the hold register, and the block moves to STALL.
  - STALL: stall_o=1 and input is ignored. The held instruction is re-evaluated every cycle. When it is hazard-free it issues, and the block returns to RUN.
- Register file: synchronous write on wbEnable_i, read at issue. Writes are never blocked by stall.
- Format 1: secValue_o = secOperand_i unchanged (16-bit immediate).
- Format 0: secValue_o = regfile[secOperand_i[4:0]]; bits [15:5] are ignored.
- When no instruction issues, enable_o=0 and the other outputs hold their last value.

## Timing
- Reset (reset_i=0 at an edge):
  - all outputs 0; busy bits and all registers cleared
  - state returns to RUN and any held instruction is dropped
  - a writeback in the reset cycle is discarded
- Latency: accept at edge N -> enable_o=1 after edge N+1 when there is no hazard.
- stall_o is registered. It is high from the edge that captures the hazard until the edge that issues the held instruction.
- Hazard cleared by a writeback in cycle W: the held instruction issues at edge W+1 with bypass, or W+2 without it.
- A writeback and a read of the same register in the same cycle return wbData_i, with bypass only.
- Back-to-back independent instructions issue every cycle (enable_o continuously 1).

## Configuration
- OPFETCH_BYPASS_EN defined: writeback data forwards to same-cycle reads, and the cleared busy bit is visible in the same cycle.
- OPFETCH_BYPASS_EN undefined: reads see only the array state, and hazard resolution costs one extra cycle.

## Structure
- Package opfetch_pkg holds:
  - DATA_W, REG_IDX_W=5, REG_COUNT
  - state enum {ST_RUN, ST_STALL}
  - a packed struct for the held instruction (format, branch, opcode, prim, sec)
- Sub-module opfetch_regfile: 32 x 16-bit storage with one synchronous write port, two asynchronous read ports, and optional bypass.

## Test plan
- Reset with wbEnable_i=1 -> all outputs 0, stall_o=0; a following read of r3 returns 0.
- Write r4=0x1234; then issue format 0, prim r1, sec r4, opcode 0x05 -> one cycle later enable_o=1, secValue_o=0x1234, r1 marked busy.
- Issue a non-branch instruction to r2; next instruction reads r2 -> stall_o=1. Writeback r2=0xBEEF in cycle W -> issue at W+1 with secValue_o=0xBEEF (W+2 without bypass).
- Format 1 with secOperand 0xFFFF, where r31 (index bits) is busy -> no stall, secValue_o=0xFFFF.
- Branch to r7 followed by a read of r7 -> no stall, since the branch sets no busy bit.
- Assert reset_i=0 during STALL -> held instruction dropped, enable_o stays 0, busy bits cleared.

Source files
------------

// File: rtl/opfetch_pkg.sv
// Shared types and sizes for the operand-fetch stage.
// Optional feature macro: OPFETCH_BYPASS_EN (writeback forwarding).
package opfetch_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 5;
    localparam int REG_COUNT = 32;
    localparam int OPC_W     = 7;

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } state_e;

    typedef struct packed {
        logic                 fmt;
        logic                 branch;
        logic [OPC_W-1:0]     opcode;
        logic [REG_IDX_W-1:0] prim;
        logic [DATA_W-1:0]    sec;
    } instr_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Parser-side, writeback and issue-side signals of the operand-fetch stage.
// Optional feature macro: OPFETCH_BYPASS_EN (no signals depend on it).
interface operand_fetch_if;
    import opfetch_pkg::*;

    logic                 enable_i;
    logic                 instructionFormat_i;
    logic                 isBranch_i;
    logic [OPC_W-1:0]     opcode_i;
    logic [REG_IDX_W-1:0] primOperand_i;
    logic [DATA_W-1:0]    secOperand_i;
    logic                 wbEnable_i;
    logic [REG_IDX_W-1:0] wbReg_i;
    logic [DATA_W-1:0]    wbData_i;

    logic                 stall_o;
    logic                 enable_o;
    logic                 instructionFormat_o;
    logic                 isBranch_o;
    logic [OPC_W-1:0]     opcode_o;
    logic [REG_IDX_W-1:0] primReg_o;
    logic [DATA_W-1:0]    primValue_o;
    logic [DATA_W-1:0]    secValue_o;

    modport master (
        output enable_i, instructionFormat_i, isBranch_i, opcode_i,
        output primOperand_i, secOperand_i,
        output wbEnable_i, wbReg_i, wbData_i,
        input  stall_o, enable_o, instructionFormat_o, isBranch_o,
        input  opcode_o, primReg_o, primValue_o, secValue_o
    );

    modport slave (
        input  enable_i, instructionFormat_i, isBranch_i, opcode_i,
        input  primOperand_i, secOperand_i,
        input  wbEnable_i, wbReg_i, wbData_i,
        output stall_o, enable_o, instructionFormat_o, isBranch_o,
        output opcode_o, primReg_o, primValue_o, secValue_o
    );

endinterface

// File: rtl/opfetch_regfile.sv
// 32 x 16 register file: one synchronous write port, two async reads.
// OPFETCH_BYPASS_EN forwards the write data to same-cycle reads.
module opfetch_regfile
    import opfetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    output logic [DATA_W-1:0]    rdata_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_b
);

    logic [DATA_W-1:0] mem_q [REG_COUNT];
    logic [DATA_W-1:0] mem_d [REG_COUNT];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef OPFETCH_BYPASS_EN
    assign rdata_a = (we && waddr == raddr_a) ? wdata : mem_q[raddr_a];
    assign rdata_b = (we && waddr == raddr_b) ? wdata : mem_q[raddr_b];
`else
    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];
`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register read, busy scoreboard and RAW stall control.
// OPFETCH_BYPASS_EN makes a writeback clear its hazard in the same cycle.
module operand_fetch
    import opfetch_pkg::*;
(
    input  logic            clock_i,
    input  logic            reset_i,
    operand_fetch_if.slave  bus
);

    state_e               state_q, state_d;
    instr_t               hold_q, hold_d;
    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic                 stall_q, stall_d;
    logic                 en_q, en_d;
    logic                 fmt_q, fmt_d;
    logic                 br_q, br_d;
    logic [OPC_W-1:0]     opc_q, opc_d;
    logic [REG_IDX_W-1:0] prim_q, prim_d;
    logic [DATA_W-1:0]    pval_q, pval_d;
    logic [DATA_W-1:0]    sval_q, sval_d;

    instr_t               in_instr, cand;
    logic                 cand_vld, hazard, issue;
    logic [REG_COUNT-1:0] wb_clr, busy_vis;
    logic [DATA_W-1:0]    rdata_a, rdata_b;

    opfetch_regfile u_rf (
        .clk     (clock_i),
        .rst_n   (reset_i),
        .we      (bus.wbEnable_i),
        .waddr   (bus.wbReg_i),
        .wdata   (bus.wbData_i),
        .raddr_a (cand.prim),
        .rdata_a (rdata_a),
        .raddr_b (cand.sec[REG_IDX_W-1:0]),
        .rdata_b (rdata_b)
    );

    always_comb begin
        in_instr = '{fmt:    bus.instructionFormat_i,
                     branch: bus.isBranch_i,
                     opcode: bus.opcode_i,
                     prim:   bus.primOperand_i,
                     sec:    bus.secOperand_i};
        cand     = (state_q == ST_STALL) ? hold_q : in_instr;
        cand_vld = (state_q == ST_STALL) || bus.enable_i;
        wb_clr   = '0;
        if (bus.wbEnable_i) begin
            wb_clr[bus.wbReg_i] = 1'b1;
        end
`ifdef OPFETCH_BYPASS_EN
        busy_vis = busy_q & ~wb_clr;
`else
        busy_vis = busy_q;
`endif
        hazard = busy_vis[cand.prim] ||
                 (!cand.fmt && busy_vis[cand.sec[REG_IDX_W-1:0]]);
        issue  = cand_vld && !hazard;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        en_d    = 1'b0;
        fmt_d   = fmt_q;
        br_d    = br_q;
        opc_d   = opc_q;
        prim_d  = prim_q;
        pval_d  = pval_q;
        sval_d  = sval_q;

        unique case (state_q)
            ST_RUN: begin
                if (cand_vld && hazard) begin
                    hold_d  = cand;
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (issue) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        stall_d = (state_d == ST_STALL);

        if (issue) begin
            en_d   = 1'b1;
            fmt_d  = cand.fmt;
            br_d   = cand.branch;
            opc_d  = cand.opcode;
            prim_d = cand.prim;
            pval_d = rdata_a;
            sval_d = cand.fmt ? cand.sec : rdata_b;
        end

        // A same-cycle issue to the written register keeps it busy
        busy_d = busy_q & ~wb_clr;
        if (issue && !cand.branch) begin
            busy_d[cand.prim] = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= ST_RUN;
            hold_q  <= '0;
            busy_q  <= '0;
            stall_q <= 1'b0;
            en_q    <= 1'b0;
            fmt_q   <= 1'b0;
            br_q    <= 1'b0;
            opc_q   <= '0;
            prim_q  <= '0;
            pval_q  <= '0;
            sval_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
            en_q    <= en_d;
            fmt_q   <= fmt_d;
            br_q    <= br_d;
            opc_q   <= opc_d;
            prim_q  <= prim_d;
            pval_q  <= pval_d;
            sval_q  <= sval_d;
        end
    end

    assign bus.stall_o             = stall_q;
    assign bus.enable_o            = en_q;
    assign bus.instructionFormat_o = fmt_q;
    assign bus.isBranch_o          = br_q;
    assign bus.opcode_o            = opc_q;
    assign bus.primReg_o           = prim_q;
    assign bus.primValue_o         = pval_q;
    assign bus.secValue_o          = sval_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed cases then random traffic.
// Honours OPFETCH_BYPASS_EN for the expected hazard-resolution latency.
module tb_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;

    always #5 clock_i = ~clock_i;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] m_rf [32];
    logic [31:0] m_busy;
    bit          m_stalled;
    logic        h_fmt, h_br;
    logic [6:0]  h_opc;
    logic [4:0]  h_prim;
    logic [15:0] h_sec;
    logic        e_en, e_fmt, e_br;
    logic [6:0]  e_opc;
    logic [4:0]  e_prim;
    logic [15:0] e_pval, e_sval;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rd(logic [4:0] r);
        if (BYP && bus.wbEnable_i && bus.wbReg_i == r) return bus.wbData_i;
        return m_rf[r];
    endfunction

    // Reference: what the stage must do at the coming rising edge
    function automatic void model_edge();
        logic [31:0] vis;
        logic        c_v, c_fmt, c_br, haz;
        logic [6:0]  c_opc;
        logic [4:0]  c_prim;
        logic [15:0] c_sec;
        if (!reset_i) begin
            foreach (m_rf[i]) m_rf[i] = '0;
            m_busy = '0;
            m_stalled = 0;
            {e_en, e_fmt, e_br, e_opc, e_prim, e_pval, e_sval} = '0;
            return;
        end
        vis = m_busy;
        if (BYP && bus.wbEnable_i) vis[bus.wbReg_i] = 1'b0;
        if (m_stalled) begin
            c_v = 1; c_fmt = h_fmt; c_br = h_br;
            c_opc = h_opc; c_prim = h_prim; c_sec = h_sec;
        end else begin
            c_v = bus.enable_i; c_fmt = bus.instructionFormat_i;
            c_br = bus.isBranch_i; c_opc = bus.opcode_i;
            c_prim = bus.primOperand_i; c_sec = bus.secOperand_i;
        end
        haz = vis[c_prim] || (!c_fmt && vis[c_sec[4:0]]);
        e_en = 1'b0;
        if (c_v && !haz) begin
            e_en = 1'b1; e_fmt = c_fmt; e_br = c_br;
            e_opc = c_opc; e_prim = c_prim;
            e_pval = rd(c_prim);
            e_sval = c_fmt ? c_sec : rd(c_sec[4:0]);
            m_stalled = 0;
        end else if (c_v && !m_stalled) begin
            h_fmt = c_fmt; h_br = c_br; h_opc = c_opc;
            h_prim = c_prim; h_sec = c_sec;
            m_stalled = 1;
        end
        if (bus.wbEnable_i) begin
            m_rf[bus.wbReg_i] = bus.wbData_i;
            m_busy[bus.wbReg_i] = 1'b0;
        end
        if (e_en && !c_br) m_busy[c_prim] = 1'b1;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clock_i);
        #1;
        check("stall_o", 32'(bus.stall_o), 32'(m_stalled));
        check("enable_o", 32'(bus.enable_o), 32'(e_en));
        check("fmt_o", 32'(bus.instructionFormat_o), 32'(e_fmt));
        check("branch_o", 32'(bus.isBranch_o), 32'(e_br));
        check("opcode_o", 32'(bus.opcode_o), 32'(e_opc));
        check("primReg_o", 32'(bus.primReg_o), 32'(e_prim));
        check("primValue_o", 32'(bus.primValue_o), 32'(e_pval));
        check("secValue_o", 32'(bus.secValue_o), 32'(e_sval));
    endtask

    task automatic drive(logic en, logic fmt, logic br, logic [6:0] opc,
                         logic [4:0] prim, logic [15:0] sec);
        bus.enable_i            = en;
        bus.instructionFormat_i = fmt;
        bus.isBranch_i          = br;
        bus.opcode_i            = opc;
        bus.primOperand_i       = prim;
        bus.secOperand_i        = sec;
    endtask

    task automatic wb(logic en, logic [4:0] r, logic [15:0] d);
        bus.wbEnable_i = en;
        bus.wbReg_i    = r;
        bus.wbData_i   = d;
    endtask

    initial begin
        int k;
        foreach (m_rf[i]) m_rf[i] = '0;
        m_busy = '0;
        m_stalled = 0;
        {h_fmt, h_br, h_opc, h_prim, h_sec} = '0;
        {e_en, e_fmt, e_br, e_opc, e_prim, e_pval, e_sval} = '0;
        drive(1'b0, 1'b0, 1'b0, 7'h0, 5'd0, 16'h0);
        wb(1'b1, 5'd3, 16'hAAAA);

        // reset with a writeback pending: it must be discarded
        reset_i = 1'b0;
        step();
        step();
        check("rst_enable", 32'(bus.enable_o), 32'd0);
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        check("rst_secval", 32'(bus.secValue_o), 32'd0);
        reset_i = 1'b1;
        wb(1'b0, 5'd0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 7'h01, 5'd0, 16'd3);
        step();
        check("r3_after_rst", 32'(bus.secValue_o), 32'h0);

        // register-form read of a written register
        drive(1'b0, 1'b0, 1'b0, 7'h0, 5'd0, 16'h0);
        wb(1'b1, 5'd4, 16'h1234);
        step();
        wb(1'b0, 5'd0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 7'h05, 5'd1, 16'd4);
        step();
        check("r4_enable", 32'(bus.enable_o), 32'd1);
        check("r4_secval", 32'(bus.secValue_o), 32'h1234);
        check("r4_opcode", 32'(bus.opcode_o), 32'h05);
        drive(1'b1, 1'b1, 1'b0, 7'h06, 5'd1, 16'h0);
        step();
        check("r1_busy_stall", 32'(bus.stall_o), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 7'h0, 5'd0, 16'h0);
        wb(1'b1, 5'd1, 16'h0101);
        step();
        wb(1'b0, 5'd0, 16'h0);
        step();
        step();

        // RAW stall released by a writeback
        drive(1'b1, 1'b1, 1'b0, 7'h03, 5'd2, 16'h0022);
        step();
        drive(1'b1, 1'b0, 1'b0, 7'h04, 5'd9, 16'd2);
        step();
        check("raw_stall", 32'(bus.stall_o), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 7'h0, 5'd0, 16'h0);
        step();
        check("raw_hold", 32'(bus.stall_o), 32'd1);
        wb(1'b1, 5'd2, 16'hBEEF);
        step();
        wb(1'b0, 5'd0, 16'h0);
        k = 1;
        while (!bus.enable_o && k < 4) begin
            step();
            k++;
        end
        check("raw_latency", 32'(k), BYP ? 32'd1 : 32'd2);
        check("raw_secval", 32'(bus.secValue_o), 32'hBEEF);

        // immediate form ignores a busy register in the index bits
        drive(1'b1, 1'b1, 1'b0, 7'h07, 5'd31, 16'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 7'h08, 5'd10, 16'hFFFF);
        step();
        check("imm_stall", 32'(bus.stall_o), 32'd0);
        check("imm_secval", 32'(bus.secValue_o), 32'hFFFF);

        // branches never mark their register busy
        drive(1'b1, 1'b1, 1'b1, 7'h09, 5'd7, 16'h0040);
        step();
        drive(1'b1, 1'b0, 1'b0, 7'h0A, 5'd7, 16'd7);
        step();
        check("branch_nostall", 32'(bus.stall_o), 32'd0);
        check("branch_enable", 32'(bus.enable_o), 32'd1);

        // reset during a stall drops the held instruction
        drive(1'b1, 1'b1, 1'b0, 7'h0B, 5'd12, 16'h0);
        step();
        drive(1'b1, 1'b0, 1'b0, 7'h0C, 5'd13, 16'd12);
        step();
        check("pre_rst_stall", 32'(bus.stall_o), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 7'h0, 5'd0, 16'h0);
        reset_i = 1'b0;
        step();
        check("rst_stall_clr", 32'(bus.stall_o), 32'd0);
        reset_i = 1'b1;
        step();
        check("held_dropped", 32'(bus.enable_o), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 7'h0D, 5'd12, 16'd12);
        step();
        check("busy_cleared", 32'(bus.stall_o), 32'd0);
        check("busy_clr_en", 32'(bus.enable_o), 32'd1);

        // random traffic on a small register window to provoke hazards
        for (int c = 0; c < 600; c++) begin
            if (!bus.stall_o) begin
                drive(($urandom_range(0, 9) < 7),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) == 0),
                      7'($urandom()),
                      5'($urandom_range(0, 7)),
                      {11'($urandom()), 5'($urandom_range(0, 7))});
            end
            wb(($urandom_range(0, 9) < 4),
               5'($urandom_range(0, 7)),
               16'($urandom()));
            reset_i = ($urandom_range(0, 99) != 0);
            step();
        end
        reset_i = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
